// File: rtl/doorbell_mbox_if.sv
// doorbell_mbox_if: request/grant register port between a host and the
// doorbell mailbox.
//   req    host -> mbox  access request (accepted in the same cycle)
//   we     host -> mbox  1 = write, 0 = read
//   addr   host -> mbox  byte address, word aligned
//   wdata  host -> mbox  write data
//   gnt    mbox -> host  grant, combinational copy of req
//   rvalid mbox -> host  response valid, one cycle after the accept edge
//   rdata  mbox -> host  read data (0 for writes and errors)
//   err    mbox -> host  unmapped address or illegal access direction
interface doorbell_mbox_if;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/doorbell_mbox.sv
// doorbell_mbox: register front-end that counts doorbell rings per channel
// and drives one level trigger per channel into the downstream doorbell FSM.
// After an ack with work still pending the trigger drops for GapCycles
// cycles so the downstream FSM sees a fresh rising edge per pending ring.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous, active-high reset
//   bus           register port (slave side of doorbell_mbox_if)
//   db_trigger_o  per-channel level trigger (flop outputs)
//
// Register map (byte offsets):
//   0x00        RING   (WO) bit i rings channel i
//   0x04        ACK    (WO) bit i acks channel i
//   0x08        STATUS (RW) [15:0] triggers, [31:16] sticky overflow, W1C
//   0x0C+4*i    COUNT_i (RO) pending count of channel i
//
// Per-channel FSM:
//   state   | meaning
//   IDLE    | nothing pending, trigger low
//   ARMED   | at least one ring pending, trigger high
//   GAP     | post-ack quiet time, trigger low, gap timer counting down
module doorbell_mbox #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned CntWidth    = 4,
  parameter int unsigned GapCycles   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  doorbell_mbox_if.slave         bus,
  output logic [NumChannels-1:0] db_trigger_o
);

  localparam int unsigned GapW = (GapCycles < 2) ? 1 : $clog2(GapCycles + 1);

  localparam logic [7:0]          AddrRing   = 8'h00;
  localparam logic [7:0]          AddrAck    = 8'h04;
  localparam logic [7:0]          AddrStatus = 8'h08;
  localparam logic [7:0]          AddrCount0 = 8'h0C;
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntMax     = '1;
  localparam logic [GapW-1:0]     GapOne     = GapW'(1);
  localparam logic [GapW-1:0]     GapInit    = GapW'(GapCycles);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e                 state_q [NumChannels];
  logic [CntWidth-1:0]    count_q [NumChannels];
  logic [GapW-1:0]        gap_q   [NumChannels];
  logic [NumChannels-1:0] trig_q;
  logic [NumChannels-1:0] ovf_q;
  logic                   rvalid_q;
  logic [31:0]            rdata_q;
  logic                   err_q;

  logic                   ring_wr, ack_wr, stat_wr;
  logic [NumChannels-1:0] ring_vec, ack_vec, clr_vec;
  logic [31:0]            rd_val;
  logic                   rd_err;
  logic                   unused_wdata;

  assign bus.gnt      = bus.req;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;
  assign db_trigger_o = trig_q;

  // Mask bits at or above NumChannels simply fall off here.
  assign ring_vec     = {NumChannels{ring_wr}} & bus.wdata[NumChannels-1:0];
  assign ack_vec      = {NumChannels{ack_wr}}  & bus.wdata[NumChannels-1:0];
  assign clr_vec      = {NumChannels{stat_wr}} & bus.wdata[16 +: NumChannels];
  assign unused_wdata = ^bus.wdata;

  // Address decode. rd_err flags both unmapped addresses and accesses in the
  // wrong direction; read data is taken from pre-edge state.
  always_comb begin
    ring_wr = 1'b0;
    ack_wr  = 1'b0;
    stat_wr = 1'b0;
    rd_val  = '0;
    rd_err  = 1'b1;
    if (bus.addr == AddrRing) begin
      rd_err  = ~bus.we;
      ring_wr = bus.req & bus.we;
    end else if (bus.addr == AddrAck) begin
      rd_err = ~bus.we;
      ack_wr = bus.req & bus.we;
    end else if (bus.addr == AddrStatus) begin
      rd_err  = 1'b0;
      stat_wr = bus.req & bus.we;
      rd_val[NumChannels-1:0]     = trig_q;
      rd_val[16 +: NumChannels]   = ovf_q;
    end else begin
      for (int i = 0; i < NumChannels; i++) begin
        if (bus.addr == AddrCount0 + 8'(4 * i)) begin
          rd_err = bus.we;
          rd_val = 32'(count_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumChannels; i++) begin
        state_q[i] <= S_IDLE;
        count_q[i] <= '0;
        gap_q[i]   <= '0;
      end
      trig_q   <= '0;
      ovf_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.req;
      err_q    <= bus.req & rd_err;
      rdata_q  <= (bus.req && !bus.we && !rd_err) ? rd_val : '0;
      ovf_q    <= ovf_q & ~clr_vec;

      for (int i = 0; i < NumChannels; i++) begin
        case (state_q[i])
          S_IDLE: begin
            if (ring_vec[i]) begin
              state_q[i] <= S_ARMED;
              count_q[i] <= CntOne;
              trig_q[i]  <= 1'b1;
            end
          end
          S_ARMED: begin
            if (ring_vec[i]) begin
              if (count_q[i] == CntMax) ovf_q[i] <= 1'b1;
              else count_q[i] <= count_q[i] + CntOne;
            end else if (ack_vec[i]) begin
              count_q[i] <= count_q[i] - CntOne;
              trig_q[i]  <= 1'b0;
              if (count_q[i] == CntOne) begin
                state_q[i] <= S_IDLE;
              end else begin
                state_q[i] <= S_GAP;
                gap_q[i]   <= GapInit;
              end
            end
          end
          S_GAP: begin
            // Terminal count at 1 so the trigger rises exactly GapCycles
            // cycles after the ack edge. Acks here are ignored.
            if (gap_q[i] == GapOne) begin
              state_q[i] <= S_ARMED;
              trig_q[i]  <= 1'b1;
            end else begin
              gap_q[i] <= gap_q[i] - GapOne;
            end
            if (ring_vec[i]) begin
              if (count_q[i] == CntMax) ovf_q[i] <= 1'b1;
              else count_q[i] <= count_q[i] + CntOne;
            end
          end
          default: begin
            state_q[i] <= S_IDLE;
            trig_q[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_doorbell_mbox.sv
module tb_doorbell_mbox;
  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int GAP = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] db_trigger_o;

  doorbell_mbox_if bus();

  doorbell_mbox #(.NumChannels(N), .CntWidth(CW), .GapCycles(GAP)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .db_trigger_o (db_trigger_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending count, remaining quiet cycles and overflow per
  // channel. A channel's trigger is high whenever it has work and is not in
  // its post-ack quiet time.
  int          m_cnt   [N];
  int          m_quiet [N];
  bit          m_ovf   [N];
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  logic        exp_err;

  function automatic logic [N-1:0] exp_trig();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = (m_cnt[c] > 0) && (m_quiet[c] == 0);
    return r;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] r;
    r = 32'(exp_trig());
    for (int c = 0; c < N; c++) r[16 + c] = m_ovf[c];
    return r;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < N; c++) begin
        m_cnt[c] = 0; m_quiet[c] = 0; m_ovf[c] = 1'b0;
      end
      exp_rvalid = 1'b0; exp_rdata = '0; exp_err = 1'b0;
    end else begin
      int a;
      logic [N-1:0] armed;
      a = int'(bus.addr);
      exp_rvalid = bus.req;
      exp_rdata  = '0;
      exp_err    = 1'b0;
      if (bus.req) begin
        if (a == 0 || a == 4) exp_err = !bus.we;
        else if (a == 8) begin
          if (!bus.we) exp_rdata = exp_status();
        end else if (a >= 12 && a < 12 + 4 * N && a % 4 == 0) begin
          if (bus.we) exp_err = 1'b1;
          else exp_rdata = 32'(m_cnt[(a - 12) / 4]);
        end else exp_err = 1'b1;
      end
      armed = exp_trig();
      for (int c = 0; c < N; c++) begin
        if (m_quiet[c] > 0) m_quiet[c]--;
        if (bus.req && bus.we && a == 0 && bus.wdata[c]) begin
          if (m_cnt[c] == MAXC) m_ovf[c] = 1'b1;
          else m_cnt[c]++;
        end
        if (bus.req && bus.we && a == 4 && bus.wdata[c] && armed[c]) begin
          m_cnt[c]--;
          m_quiet[c] = (m_cnt[c] > 0) ? GAP : 0;
        end
        if (bus.req && bus.we && a == 8 && bus.wdata[16 + c]) m_ovf[c] = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("trigger", 32'(db_trigger_o), 32'(exp_trig()));
      chk("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("rdata", bus.rdata, exp_rdata);
      chk("gnt", 32'(bus.gnt), 32'(bus.req));
    end
  end

  // One access; returns #1 after the accept edge with the response visible.
  task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    @(negedge clk_i);
    #1;
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk_i);
    #1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = '0;
  endtask

  task automatic rd_lit(input string name, input logic [7:0] addr,
                        input logic [31:0] exp_d, input logic exp_e);
    access(1'b0, addr, 32'h0);
    chk({name, "_rdata"}, bus.rdata, exp_d);
    chk({name, "_err"}, 32'(bus.err), 32'(exp_e));
  endtask

  task automatic cycle_then_trig(input string name, input logic [N-1:0] exp);
    @(posedge clk_i);
    #1;
    chk(name, 32'(db_trigger_o), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    rd_lit("reset_status", 8'h08, 32'h0000_0000, 1'b0);
    chk("reset_trig", 32'(db_trigger_o), 32'h0);

    access(1'b1, 8'h00, 32'h1);
    chk("ring0_trig", 32'(db_trigger_o), 32'h1);
    rd_lit("ring0_count", 8'h0C, 32'd1, 1'b0);
    access(1'b1, 8'h04, 32'h1);
    chk("ack_to_idle_trig", 32'(db_trigger_o), 32'h0);

    repeat (3) access(1'b1, 8'h00, 32'h1);
    access(1'b1, 8'h04, 32'h1);
    chk("gap_a0", 32'(db_trigger_o), 32'h0);
    cycle_then_trig("gap_a1", 4'h0);
    cycle_then_trig("gap_a2", 4'h1);
    rd_lit("count0_after_ack", 8'h0C, 32'd2, 1'b0);
    access(1'b1, 8'h04, 32'h1);
    chk("gap_b0", 32'(db_trigger_o), 32'h0);
    cycle_then_trig("gap_b1", 4'h0);
    cycle_then_trig("gap_b2", 4'h1);
    access(1'b1, 8'h04, 32'h1);
    chk("last_ack_trig", 32'(db_trigger_o), 32'h0);
    cycle_then_trig("idle_stays_low", 4'h0);
    rd_lit("count0_zero", 8'h0C, 32'd0, 1'b0);

    repeat (16) access(1'b1, 8'h00, 32'h2);
    rd_lit("count1_sat", 8'h10, 32'd15, 1'b0);
    rd_lit("status_ovf", 8'h08, 32'h0002_0002, 1'b0);
    access(1'b1, 8'h08, 32'h0002_0000);
    chk("status_wr_err", 32'(bus.err), 32'h0);
    rd_lit("status_cleared", 8'h08, 32'h0000_0002, 1'b0);
    rd_lit("count1_kept", 8'h10, 32'd15, 1'b0);

    access(1'b1, 8'h04, 32'h4);
    chk("ack_idle_err", 32'(bus.err), 32'h0);
    rd_lit("count2_idle", 8'h14, 32'd0, 1'b0);
    rd_lit("unmapped", 8'hFC, 32'h0, 1'b1);
    rd_lit("read_ring", 8'h00, 32'h0, 1'b1);
    rd_lit("read_ack", 8'h04, 32'h0, 1'b1);
    access(1'b1, 8'h0C, 32'h5);
    chk("write_count_err", 32'(bus.err), 32'h1);

    access(1'b1, 8'h00, 32'hFF);
    chk("multi_ring_trig", 32'(db_trigger_o), 32'hF);
    rd_lit("multi_status", 8'h08, 32'h0002_000F, 1'b0);

    repeat (3) access(1'b1, 8'h00, 32'h8);
    access(1'b1, 8'h04, 32'h8);
    chk("ch3_gap_trig", 32'(db_trigger_o), 32'h7);
    rd_lit("count3_before_rst", 8'h18, 32'd3, 1'b0);
    access(1'b1, 8'h04, 32'h0);
    @(negedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("rst_trig", 32'(db_trigger_o), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < N; c++) rd_lit("count_after_rst", 8'(12 + 4 * c), 32'd0, 1'b0);
    rd_lit("status_after_rst", 8'h08, 32'h0, 1'b0);

    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
